// File: rtl/systolic_pkg.sv
// Shared processing-element definitions: default operand geometry, accumulator
// width rule and the slot-reservation state encoding.
package systolic_pkg;

    localparam int unsigned N_DEF       = 32;
    localparam int unsigned K_DEF       = 4;
    localparam int unsigned MUL_LAT_DEF = 2;

    // A sum of k products of two n-bit signed operands cannot overflow this width.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned k);
        return 2 * n + $clog2(k);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        WAIT = 2'd2
    } slot_state_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry result queue; the head register drives the consumer directly.
module result_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         pop_en;

    assign pop_en = pop & (count != 2'd0);
    assign dout   = head;
    assign valid  = (count != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop_en})
                2'b10: begin
                    if (count != 2'd2) begin
                        if (count == 2'd0) head <= din;
                        else               tail <= din;
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop leaves the count unchanged in either occupancy.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/booth_dot_accumulator.sv
// Accumulates K consecutive multiplier products into one dot-product result and
// throttles the operand feeder so every started dot product has a queue slot.
module booth_dot_accumulator
    import systolic_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned K       = K_DEF,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned ACC_W   = acc_width(N, K)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [2*N-1:0]   Prod,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int unsigned CW  = $clog2(K);
    localparam int unsigned EXT = ACC_W - 2 * N;

    logic [MUL_LAT-1:0]      vpipe;
    logic                    pvalid;
    logic                    accept;
    logic                    start;
    logic [CW-1:0]           acc_cnt;
    logic [CW-1:0]           prd_cnt;
    logic                    last_acc;
    logic                    last_prd;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] res_q;
    logic                    res_v;
    logic                    push;
    logic [1:0]              reserved;
    logic [1:0]              fifo_count;
    logic [ACC_W-1:0]        fifo_dout;
    slot_state_t             state;

    assign accept   = in_valid & in_ready;
    assign start    = accept & (acc_cnt == '0);
    assign pvalid   = vpipe[MUL_LAT-1];
    assign last_acc = (acc_cnt == CW'(K - 1));
    assign last_prd = (prd_cnt == CW'(K - 1));
    assign prod_ext = {{EXT{Prod[2*N-1]}}, Prod};
    assign sum      = acc + prod_ext;
    assign push     = res_v;
    assign in_ready = (acc_cnt != '0) | (({1'b0, fifo_count} + {1'b0, reserved}) < 3'd2);
    assign busy     = (state != IDLE);
    assign out_data = fifo_dout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe   <= '0;
            acc_cnt <= '0;
            prd_cnt <= '0;
        end else begin
            vpipe <= (vpipe << 1) | MUL_LAT'(accept);
            if (accept)
                acc_cnt <= last_acc ? '0 : acc_cnt + CW'(1);
            if (pvalid)
                prd_cnt <= last_prd ? '0 : prd_cnt + CW'(1);
        end
    end

    // The finished sum is staged one cycle before entering the queue, so a result
    // appears MUL_LAT+1 edges after its last operand is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            res_q <= '0;
            res_v <= 1'b0;
        end else begin
            res_v <= pvalid & last_prd;
            if (pvalid) begin
                if (last_prd) begin
                    res_q <= sum;
                    acc   <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    // Credits are released only when the result actually lands in the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reserved <= '0;
            state    <= IDLE;
        end else begin
            reserved <= reserved + 2'(start) - 2'(push);
            case (state)
                IDLE: if (start) state <= OPEN;
                OPEN: if (accept && last_acc) state <= WAIT;
                WAIT: begin
                    if (start)
                        state <= OPEN;
                    else if (push && reserved == 2'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    result_fifo2 #(
        .W(ACC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (res_q),
        .pop   (out_valid & out_ready),
        .dout  (fifo_dout),
        .valid (out_valid),
        .count (fifo_count)
    );

endmodule

// File: doc/booth_dot_accumulator.md
# booth_dot_accumulator

Downstream consumer of `radix8_booth_multiplier` inside a systolic-array processing element. It tracks which multiplier products are valid, accumulates K consecutive signed products into one dot-product term, and buffers finished results in a 2-entry output queue with valid/ready handshake. It throttles the operand feeder through `in_ready` because the multiplier pipeline cannot stall.

## Interface
- `N`, 32, operand width seen by the multiplier; `Prod` is 2N bits.
- `K`, 4, products per dot product; must be ≥ 2.
- `MUL_LAT`, 2, cycles from operands presented with `in_valid` to the matching `Prod` on the input port.
- `ACC_W`, 2N+$clog2(K), accumulator and result width; overflow is impossible by construction.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset; the same net drives the multiplier.
- `in_valid`  in  1  operands a/b are being presented to the multiplier this cycle.
- `in_ready`  out  1  the feeder may assert `in_valid`; an operand is accepted only when both are high.
- `Prod`  in  2N signed  multiplier output.
- `out_data`  out  ACC_W signed  head of the result queue.
- `out_valid`  out  1  `out_data` holds a finished dot product.
- `out_ready`  in  1  the consumer takes the head when it is high together with `out_valid`.
- `busy`  out  1  a dot product is partially accepted or products are still in flight.

## Operation
- **Valid alignment.** `vpipe` is a MUL_LAT-deep shift register loaded with `in_valid & in_ready`. `pvalid = vpipe[MUL_LAT-1]` marks a valid `Prod`.
- **Accept counter.** `acc_cnt` runs 0..K-1 and advances on each accepted operand. `prd_cnt` runs 0..K-1 and advances on each `pvalid`. Both wrap to 0.
- **Accumulation.** On `pvalid`, `Prod` is sign-extended to ACC_W.
  - If `prd_cnt == K-1`: `acc + ext(Prod)` is pushed to the queue and `acc` clears to 0.
  - Otherwise: `acc <= acc + ext(Prod)`.
- **Slot reservation state machine.**
  - States:
    - `IDLE`: no reservation.
    - `OPEN`: operands of the current dot product are still being accepted.
    - `WAIT`: all K are accepted; products are in flight.
  - Transitions:
    - IDLE→OPEN on an accept with `acc_cnt == 0`.
    - OPEN→WAIT on the accept with `acc_cnt == K-1`.
    - WAIT→IDLE on the push.
    - WAIT→OPEN when a new dot product's first accept falls in the same cycle as the push.
- **Credits.** `reserved` counts dot products in OPEN/WAIT whose result has not yet been pushed, max 2.
  - Condition: `in_ready = (acc_cnt != 0) | (fifo_count + reserved < 2)`.
  - Effect: a dot product that has started is never stalled mid-stream for lack of a slot; a new one starts only when a slot is guaranteed.
- **Result queue.** 2 entries; `out_data`/`out_valid` come from the head.
  - Push and pop in the same cycle while the queue is full is legal and keeps the count at 2.
  - A push into a full queue cannot occur, because the credit rule prevents it.
- **Reset mid-operation.** Assertion of `rst` immediately clears `vpipe`, both counters, `acc`, `reserved`, the queue, and the state (→IDLE). Products still in flight from the multiplier are discarded because their valid bits are gone.

## Timing
- **Reset values:** `in_ready=1`, `out_valid=0`, `out_data=0`, `busy=0`.
- **Latency:** the last operand accepted at edge t makes `out_valid` high after edge t+MUL_LAT+1, provided the queue was empty.
- **Throughput:** one operand per cycle sustained while `out_ready=1`, giving one result every K cycles.
- **Reset release:** `in_ready` is combinational from registered state only. The first accept can occur on the first edge after `rst` deasserts.
- **Pop:** `out_valid` drops, or the next entry advances, on the edge where `out_valid & out_ready`.

## Structure
- **Shared package `systolic_pkg`:** default `N`, `K`, `MUL_LAT`; the ACC_W width function; the `IDLE/OPEN/WAIT` enum. The PE and array top reuse these.
- **Sub-module `result_fifo2`:** the 2-entry queue (push, pop, count, head). Its async active-low reset matches the parent's.

## Test plan
- **Dot product with mixed signs.** K=4, MUL_LAT=2, stimulus (-6,4), (7,-2), (-5,-3), (0,15) on consecutive cycles, `out_ready=1` → one result of -23, `out_valid` high for exactly one cycle, 3 edges after the last accept.
- **Back-to-back dot products.** (127,127), (-126,-1), (0,0), (0,0) immediately followed by the previous vector → results 16255 then -23, with no idle cycle on `in_ready`.
- **Extreme operands.** Four products of (-2^31)×(-2^31) → `out_data` = 2^64 in the 66-bit result, with the sign bit 0.
- **Backpressure.** `out_ready=0`, continuous `in_valid` → two results queued, then `in_ready=0` at the first element of the third dot product. After raising `out_ready` for one cycle, `in_ready` returns to 1 and no result is lost or duplicated.
- **Reset mid-operation.** Pulse `rst` low after 2 of 4 operands are accepted → all outputs return to reset values. The next 4-operand vector yields only its own sum, with no residue from before the reset.
- **Push/pop collision.** Queue full with `out_ready=1` on the cycle a third result is pushed → count stays 2 and ordering is preserved.
